// File: rtl/gpio_irq_pkg.sv
// Shared definitions for the parametrised GPIO block: register offsets,
// interrupt-mode encodings and the address decoder used by the top level.
package gpio_irq_pkg;

  localparam logic [7:0] GPIO_DIR      = 8'h00;
  localparam logic [7:0] GPIO_DOUT     = 8'h04;
  localparam logic [7:0] GPIO_DIN      = 8'h08;
  localparam logic [7:0] GPIO_IE       = 8'h0C;
  localparam logic [7:0] GPIO_ITYPE    = 8'h10;
  localparam logic [7:0] GPIO_IPOL     = 8'h14;
  localparam logic [7:0] GPIO_IP       = 8'h18;
  localparam logic [7:0] GPIO_DOUT_SET = 8'h1C;
  localparam logic [7:0] GPIO_DOUT_CLR = 8'h20;
  localparam logic [7:0] GPIO_DOUT_TGL = 8'h24;

  localparam logic ITYPE_LEVEL = 1'b0;
  localparam logic ITYPE_EDGE  = 1'b1;
  localparam logic IPOL_LOW    = 1'b0;
  localparam logic IPOL_HIGH   = 1'b1;

  typedef enum logic [3:0] {
    REG_DIR,
    REG_DOUT,
    REG_DIN,
    REG_IE,
    REG_ITYPE,
    REG_IPOL,
    REG_IP,
    REG_DOUT_SET,
    REG_DOUT_CLR,
    REG_DOUT_TGL,
    REG_NONE
  } gpio_reg_e;

  function automatic gpio_reg_e gpio_decode(input logic [7:0] off);
    gpio_reg_e r;
    case (off)
      GPIO_DIR:      r = REG_DIR;
      GPIO_DOUT:     r = REG_DOUT;
      GPIO_DIN:      r = REG_DIN;
      GPIO_IE:       r = REG_IE;
      GPIO_ITYPE:    r = REG_ITYPE;
      GPIO_IPOL:     r = REG_IPOL;
      GPIO_IP:       r = REG_IP;
      GPIO_DOUT_SET: r = REG_DOUT_SET;
      GPIO_DOUT_CLR: r = REG_DOUT_CLR;
      GPIO_DOUT_TGL: r = REG_DOUT_TGL;
      default:       r = REG_NONE;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/gpio_sync.sv
// Vector multi-flop synchroniser for asynchronous inputs; q is the last stage.
module gpio_sync #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] sync_p [STAGES];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) sync_p[k] <= '0;
    end else begin
      sync_p[0] <= d;
      for (int k = 1; k < STAGES; k++) sync_p[k] <= sync_p[k-1];
    end
  end

  assign q = sync_p[STAGES-1];

endmodule

// File: rtl/gpio_irq.sv
// Parametrised GPIO slave on the RIB: direction/data registers, synchronised
// inputs and per-pin edge/level interrupts with write-1-to-clear pending bits.
module gpio_irq
  import gpio_irq_pkg::*;
#(
  parameter int                NUM_IO      = 16,
  parameter int                SYNC_STAGES = 2,
  parameter logic [NUM_IO-1:0] DIR_RST     = '0,
  parameter logic [NUM_IO-1:0] DOUT_RST    = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we_i,
  input  logic [31:0]       addr_i,
  input  logic [31:0]       data_i,
  output logic [31:0]       data_o,
  input  logic [NUM_IO-1:0] io_pin_i,
  output logic [NUM_IO-1:0] io_out_o,
  output logic [NUM_IO-1:0] io_oe_o,
  output logic              int_o
);

  gpio_reg_e         sel;
  logic [NUM_IO-1:0] wr_val;
  logic [NUM_IO-1:0] dir, dout, ie, itype, ipol, ip;
  logic [NUM_IO-1:0] din, din_prev;
  logic [NUM_IO-1:0] rise, fall, level_hit, evt, w1c;
  logic              wr_en;
  logic              unused_ok;

  assign sel    = gpio_decode(addr_i[7:0]);
  assign wr_val = data_i[NUM_IO-1:0];
  assign wr_en  = we_i;

  // Only the low byte of the address and the low NUM_IO data bits matter.
  assign unused_ok = &{1'b0, addr_i[31:8], data_i};

  gpio_sync #(
    .WIDTH  (NUM_IO),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (io_pin_i),
    .q   (din)
  );

  // Event detection: compare the synchronised value with last cycle's copy.
  assign rise      = din & ~din_prev;
  assign fall      = ~din & din_prev;
  assign level_hit = ~(din ^ ipol);
  assign evt       = (itype & ((ipol & rise) | (~ipol & fall)))
                   | (~itype & level_hit);

  assign w1c = (wr_en && sel == REG_IP) ? wr_val : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      dir      <= DIR_RST;
      dout     <= DOUT_RST;
      ie       <= '0;
      itype    <= '0;
      ipol     <= '0;
      ip       <= '0;
      din_prev <= '0;
      int_o    <= 1'b0;
    end else begin
      din_prev <= din;
      // A fresh event beats a simultaneous clear, so nothing is lost.
      ip       <= evt | (ip & ~w1c);
      int_o    <= |(ip & ie);
      if (wr_en) begin
        case (sel)
          REG_DIR:      dir   <= wr_val;
          REG_DOUT:     dout  <= wr_val;
          REG_IE:       ie    <= wr_val;
          REG_ITYPE:    itype <= wr_val;
          REG_IPOL:     ipol  <= wr_val;
          REG_DOUT_SET: dout  <= dout | wr_val;
          REG_DOUT_CLR: dout  <= dout & ~wr_val;
          REG_DOUT_TGL: dout  <= dout ^ wr_val;
          default:      ;
        endcase
      end
    end
  end

  always_comb begin
    data_o = '0;
    case (sel)
      REG_DIR:   data_o[NUM_IO-1:0] = dir;
      REG_DOUT:  data_o[NUM_IO-1:0] = dout;
      REG_DIN:   data_o[NUM_IO-1:0] = din;
      REG_IE:    data_o[NUM_IO-1:0] = ie;
      REG_ITYPE: data_o[NUM_IO-1:0] = itype;
      REG_IPOL:  data_o[NUM_IO-1:0] = ipol;
      REG_IP:    data_o[NUM_IO-1:0] = ip;
      default:   data_o = '0;
    endcase
  end

  assign io_out_o = dout;
  assign io_oe_o  = dir;

endmodule

// File: tb/tb_gpio_irq.sv
// Scoreboard bench for gpio_irq: stimulus queues expected values, a monitor
// on the falling clock edge pops and compares them against the DUT outputs.
module tb_gpio_irq;

  localparam int N = 16;

  localparam int S_DATA  = 0;
  localparam int S_OUT   = 1;
  localparam int S_OE    = 2;
  localparam int S_IRQ   = 3;
  localparam int S_DATA4 = 4;
  localparam int S_IRQ4  = 5;
  localparam int S_OUT4  = 6;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          we = 1'b0, we4 = 1'b0;
  logic [31:0]   addr = '0, wdata = '0;
  logic [31:0]   rdata, rdata4;
  logic [N-1:0]  pins = '0, io_out, io_oe;
  logic [3:0]    pins4 = '0, io_out4, io_oe4;
  logic          irq, irq4;

  always #5 clk = ~clk;

  gpio_irq dut (
    .clk(clk), .rst(rst), .we_i(we), .addr_i(addr), .data_i(wdata),
    .data_o(rdata), .io_pin_i(pins), .io_out_o(io_out), .io_oe_o(io_oe),
    .int_o(irq)
  );

  gpio_irq #(.NUM_IO(4), .SYNC_STAGES(3)) dut4 (
    .clk(clk), .rst(rst), .we_i(we4), .addr_i(addr), .data_i(wdata),
    .data_o(rdata4), .io_pin_i(pins4), .io_out_o(io_out4), .io_oe_o(io_oe4),
    .int_o(irq4)
  );

  int          sel_q[$];
  logic [31:0] exp_q[$];
  string       name_q[$];
  int          n_chk = 0;
  int          n_err = 0;

  always @(negedge clk) begin
    while (sel_q.size() > 0) begin
      int          s;
      logic [31:0] e, a;
      string       nm;
      s  = sel_q.pop_front();
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      case (s)
        S_DATA:  a = rdata;
        S_OUT:   a = {16'b0, io_out};
        S_OE:    a = {16'b0, io_oe};
        S_IRQ:   a = {31'b0, irq};
        S_DATA4: a = rdata4;
        S_IRQ4:  a = {31'b0, irq4};
        S_OUT4:  a = {28'b0, io_out4};
        default: a = 'x;
      endcase
      n_chk++;
      if (a !== e) begin
        n_err++;
        $display("FAIL %s: got 0x%08h expected 0x%08h", nm, a, e);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_v(input int s, input logic [31:0] e, input string nm);
    sel_q.push_back(s);
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  task automatic wr(input bit u, input logic [7:0] a, input logic [31:0] d);
    addr  = {24'b0, a};
    wdata = d;
    if (u) we4 = 1'b1;
    else   we  = 1'b1;
    cyc();
    we  = 1'b0;
    we4 = 1'b0;
  endtask

  task automatic rd(input bit u, input logic [7:0] a, input logic [31:0] e, input string nm);
    addr = {24'b0, a};
    we   = 1'b0;
    we4  = 1'b0;
    expect_v(u ? S_DATA4 : S_DATA, e, nm);
    cyc();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    cyc();
    cyc();
    // Reset values, read while rst is held
    expect_v(S_OE, 32'h0, "rst_oe");
    expect_v(S_IRQ, 32'h0, "rst_irq");
    expect_v(S_IRQ4, 32'h0, "rst_irq4");
    expect_v(S_OUT4, 32'h0, "rst_out4");
    rd(0, 8'h00, 32'h0, "rst_dir");
    rd(0, 8'h04, 32'h0, "rst_dout");
    rd(0, 8'h18, 32'h0, "rst_ip");
    rd(0, 8'h28, 32'h0, "unmapped_28");
    rd(1, 8'h00, 32'h0, "rst_dir4");

    rst = 1'b0;
    cyc();
    wr(0, 8'h10, 32'hFFFF);
    wr(0, 8'h14, 32'hFFFF);
    wr(0, 8'h18, 32'hFFFF);
    rd(0, 8'h18, 32'h0, "ip_clear_init");

    // DOUT and the set/clear/toggle aliases
    wr(0, 8'h04, 32'h00F0);
    expect_v(S_OUT, 32'h00F0, "dout_write");
    wr(0, 8'h1C, 32'h0003);
    expect_v(S_OUT, 32'h00F3, "dout_set");
    wr(0, 8'h20, 32'h0010);
    expect_v(S_OUT, 32'h00E3, "dout_clr");
    wr(0, 8'h24, 32'h8001);
    expect_v(S_OUT, 32'h80E2, "dout_tgl");
    wr(0, 8'h2C, 32'hFFFF_FFFF);
    rd(0, 8'h04, 32'h80E2, "dout_after_unmapped_wr");
    rd(0, 8'h1C, 32'h0, "set_reads_zero");
    wr(0, 8'h00, 32'hABCD_00FF);
    expect_v(S_OE, 32'h00FF, "dir_oe");
    rd(0, 8'h00, 32'h00FF, "dir_upper_ignored");

    // Pin 5 rising edge with latency
    wr(0, 8'h0C, 32'h20);
    pins[5] = 1'b1;
    expect_v(S_IRQ, 32'h0, "irq5_e0");
    rd(0, 8'h08, 32'h0, "din5_e0");
    rd(0, 8'h08, 32'h0, "din5_e1");
    rd(0, 8'h08, 32'h20, "din5_e2");
    expect_v(S_IRQ, 32'h0, "irq5_e3");
    rd(0, 8'h18, 32'h20, "ip5_e3");
    expect_v(S_IRQ, 32'h1, "irq5_e4");
    wr(0, 8'h18, 32'h20);
    expect_v(S_IRQ, 32'h1, "irq5_clr_lag");
    rd(0, 8'h18, 32'h0, "ip5_clr");
    expect_v(S_IRQ, 32'h0, "irq5_low");

    // Pin 0 falling edge colliding with its own W1C, then IE masking
    wr(0, 8'h0C, 32'h0);
    wr(0, 8'h14, 32'hFFFE);
    pins[0] = 1'b1;
    cyc(); cyc(); cyc();
    rd(0, 8'h18, 32'h0, "ip0_quiet_rise");
    pins[0] = 1'b0;
    cyc(); cyc();
    wr(0, 8'h18, 32'h1);
    rd(0, 8'h18, 32'h1, "ip0_collide");
    expect_v(S_IRQ, 32'h0, "irq_masked");
    wr(0, 8'h0C, 32'h1);
    expect_v(S_IRQ, 32'h0, "irq_unmask_lag");
    cyc();
    expect_v(S_IRQ, 32'h1, "irq_unmask");
    wr(0, 8'h18, 32'h1);
    rd(0, 8'h18, 32'h0, "ip0_w1c");
    wr(0, 8'h0C, 32'h0);

    // Pin 3 level-low: re-sets while low, clears once high
    wr(0, 8'h10, 32'hFFF7);
    wr(0, 8'h14, 32'hFFF6);
    cyc();
    rd(0, 8'h18, 32'h08, "ip3_level");
    wr(0, 8'h18, 32'h08);
    rd(0, 8'h18, 32'h08, "ip3_w1c_hold");
    pins[3] = 1'b1;
    cyc(); cyc(); cyc();
    wr(0, 8'h18, 32'h08);
    rd(0, 8'h18, 32'h0, "ip3_cleared");
    rd(0, 8'h18, 32'h0, "ip3_stays");
    wr(0, 8'h10, 32'hFFFF);
    wr(0, 8'h14, 32'hFFFF);

    // One-cycle glitch on pin 7 in rising-edge mode
    pins[7] = 1'b1;
    cyc();
    pins[7] = 1'b0;
    cyc(); cyc();
    rd(0, 8'h18, 32'h80, "ip7_glitch");
    wr(0, 8'h18, 32'h80);
    rd(0, 8'h18, 32'h0, "ip7_clr");

    // Reset mid-operation with pin 9 held high
    pins[9] = 1'b1;
    cyc(); cyc(); cyc();
    wr(0, 8'h18, 32'hFFFF);
    rst = 1'b1;
    cyc();
    expect_v(S_OE, 32'h0, "rst2_oe");
    expect_v(S_OUT, 32'h0, "rst2_out");
    rd(0, 8'h04, 32'h0, "rst2_dout");
    rst = 1'b0;
    cyc(); cyc(); cyc(); cyc();
    wr(0, 8'h10, 32'hFFFF);
    wr(0, 8'h14, 32'hFFFF);
    wr(0, 8'h18, 32'hFFFF);
    rd(0, 8'h18, 32'h0, "ip_no_rise_after_rst");
    rd(0, 8'h08, 32'h0228, "din_after_rst");

    // Narrow instance: 4 pins, 3 synchroniser stages
    wr(1, 8'h00, 32'hFFFF_FFFF);
    rd(1, 8'h00, 32'hF, "d4_dir_mask");
    wr(1, 8'h0C, 32'h5A);
    rd(1, 8'h0C, 32'hA, "d4_ie_mask");
    wr(1, 8'h04, 32'h36);
    expect_v(S_OUT4, 32'h6, "d4_out_mask");
    pins4 = 4'b1010;
    rd(1, 8'h08, 32'h0, "d4_din_e0");
    rd(1, 8'h08, 32'h0, "d4_din_e1");
    rd(1, 8'h08, 32'h0, "d4_din_e2");
    rd(1, 8'h08, 32'hA, "d4_din_e3");
    rd(1, 8'h28, 32'h0, "d4_unmapped");

    cyc();
    if (sel_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d pending expected 0", sel_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
